ltl_violation_collector: RTL and testbench
==========================================

Name: ltl_violation_collector

Overview:
Downstream consumer of a cluster's LTL monitor flags (ltl0..ltl8 packed into one vector). It timestamps every cycle in which any property fires and captures the offending symbol. Events are buffered in a small FIFO and drained over a valid/ready port to the trace/logging unit. It also keeps per-property sticky flags, saturating hit counters and a dropped-event counter for software readout.

Parameters:
NUM_PROPS, 9, number of property flags (bit i = ltl<i>).
DEPTH, 8, event FIFO entries; power of two, >=2.
STAMP_W, 32, run-cycle timestamp width.
CNT_W, 16, width of per-property hit counters and drop counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
run  in  1  qualifier; all monitor inputs are ignored when 0.
symbols  in  8  symbol aligned with viol (same cycle).
viol  in  NUM_PROPS  monitor flags, bit i = ltl<i>.
clr  in  1  synchronous clear of sticky, hit counters and drop_cnt.
evt_valid  out  1  FIFO head valid.
evt_ready  in  1  consumer accepts head.
evt_stamp  out  STAMP_W  head timestamp.
evt_symbol  out  8  head symbol.
evt_viol  out  NUM_PROPS  head flag vector.
fifo_level  out  clog2(DEPTH)+1  occupied entries.
sticky  out  NUM_PROPS  per-property sticky flags.
any_viol  out  1  OR of sticky, registered.
drop_cnt  out  CNT_W  events lost to full FIFO, saturating.
cnt_sel  in  4  hit-counter select.
cnt_rdata  out  CNT_W  selected hit counter.

Behaviour:
- Reset (reset=0, async): stamp, FIFO pointers/level, sticky, any_viol, hit counters, drop_cnt, cnt_rdata all 0; evt_valid=0; evt_* fields 0. Effect is immediate, including mid-drain; all partial state is discarded.
- Stamp: counter increments by 1 on each clk edge with run=1; holds when run=0. It wraps modulo 2^STAMP_W. The stamp captured with an event is the pre-increment value, so the first run cycle after reset is stamp 0.
- Event qualification: push_req = run & |viol. An entry {stamp, symbols, viol} is written on that edge.
- FIFO: first-word-fall-through.
  - evt_valid = (level != 0), registered.
  - Latency from violation cycle to evt_valid is 1 cycle when the FIFO was empty.
  - Pop occurs when evt_valid & evt_ready.
  - When evt_valid=0, evt_stamp/evt_symbol/evt_viol are driven 0.
  - Head contents and evt_valid stay stable until popped; no retraction.
- Full handling:
  - Full with pop in the same cycle: push accepted, level stays DEPTH, drop_cnt unchanged.
  - Full without pop: the push is dropped and drop_cnt increments, saturating at 2^CNT_W-1.
  - Empty with push and evt_ready=1: no bypass; the entry appears next cycle.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- Sticky: sticky <= sticky | (run ? viol : 0). any_viol <= |next_sticky, so it updates on the same edge as sticky.
- Hit counters: cnt[i] increments when run & viol[i], saturating at 2^CNT_W-1.
- clr:
  - Next sticky = run ? viol : 0; cnt[i] = (run & viol[i]) ? 1 : 0; drop_cnt = 0. A coincident event therefore wins over the clear.
  - If the same edge drops a push, drop_cnt becomes 1.
  - clr does not touch the FIFO or the stamp.
- cnt_rdata <= (cnt_sel < NUM_PROPS) ? cnt[cnt_sel] (pre-update value) : 0. Read latency is 1 cycle.
- Flags are assumed already registered by the monitor. No additional input pipelining is added.

Test Plan:
1. Reset, then run=1, viol=0 for 5 cycles; then viol=9'h004, symbols=8'hA5 for 1 cycle, evt_ready=0.
   -> Next cycle: evt_valid=1, evt_stamp=5, evt_symbol=A5, evt_viol=004, sticky=004, any_viol=1, fifo_level=1.
   -> Raising evt_ready pops; evt_valid=0 the following cycle.
2. run=0, viol=1FF for 3 cycles.
   -> No push, sticky=0, hit counters 0, stamp frozen (next event stamp unchanged).
3. DEPTH=8, evt_ready=0, 10 consecutive cycles with viol=001 from stamp 0.
   -> fifo_level=8, drop_cnt=2; draining yields stamps 0..7 in order, then evt_valid=0.
4. FIFO full, evt_ready=1 and a new violation on the same cycle.
   -> fifo_level stays 8, drop_cnt unchanged, new entry emerges last in drain order.
5. CNT_W=4, 20 cycles of viol=008.
   -> cnt_sel=3 gives cnt_rdata=15 one cycle later; cnt_sel=12 gives 0; cnt_sel=0 gives 0.
6. clr coincident with viol=002 after prior sticky=1FF.
   -> sticky=002, cnt[1]=1, other counters 0, drop_cnt=0, FIFO contents intact.
   -> Then reset asserted mid-drain: evt_valid, fifo_level, sticky and any_viol go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ltl_violation_collector.sv
// Timestamps cycles where any LTL property fires; buffers {stamp,symbol,flags} in a FWFT FIFO, plus sticky/hit/drop stats.
// Event visible 1 cycle after violation; full FIFO without pop drops and counts; head held until evt_ready.
module ltl_violation_collector #(
  parameter int NUM_PROPS = 9,
  parameter int DEPTH     = 8,
  parameter int STAMP_W   = 32,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [7:0]                   symbols,
  input  logic [NUM_PROPS-1:0]         viol,
  input  logic                         clr,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [STAMP_W-1:0]           evt_stamp,
  output logic [7:0]                   evt_symbol,
  output logic [NUM_PROPS-1:0]         evt_viol,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic [NUM_PROPS-1:0]         sticky,
  output logic                         any_viol,
  output logic [CNT_W-1:0]             drop_cnt,
  input  logic [3:0]                   cnt_sel,
  output logic [CNT_W-1:0]             cnt_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [STAMP_W-1:0]   stamp;
    logic [7:0]           symbol;
    logic [NUM_PROPS-1:0] viol;
  } evt_t;

  evt_t                 mem [DEPTH];
  evt_t                 head;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level, level_nxt;
  logic [STAMP_W-1:0]   stamp;
  logic [CNT_W-1:0]     cnt [NUM_PROPS];
  logic [CNT_W-1:0]     cnt_sel_val;
  logic                 vld;
  logic                 push_req, pop, full, push_ok, drop;
  logic [NUM_PROPS-1:0] hits, sticky_nxt;

  assign hits       = run ? viol : '0;
  assign push_req   = |hits;
  assign pop        = vld & evt_ready;
  assign full       = (level == LW'(DEPTH));
  // A pop on a full FIFO frees the slot the push lands in this same edge.
  assign push_ok    = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;
  assign level_nxt  = level + LW'(push_ok) - LW'(pop);
  assign sticky_nxt = (clr ? '0 : sticky) | hits;

  // Stale memory is masked so the event fields read 0 whenever nothing is queued.
  always_comb head = vld ? mem[rd_ptr] : '0;

  assign evt_valid  = vld;
  assign evt_stamp  = head.stamp;
  assign evt_symbol = head.symbol;
  assign evt_viol   = head.viol;
  assign fifo_level = level;

  always_comb begin
    cnt_sel_val = '0;
    for (int i = 0; i < NUM_PROPS; i++)
      if (int'(cnt_sel) == i) cnt_sel_val = cnt[i];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{stamp: stamp, symbol: symbols, viol: viol};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stamp     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      vld       <= 1'b0;
      sticky    <= '0;
      any_viol  <= 1'b0;
      drop_cnt  <= '0;
      cnt_rdata <= '0;
      for (int i = 0; i < NUM_PROPS; i++) cnt[i] <= '0;
    end else begin
      if (run)     stamp  <= stamp + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level    <= level_nxt;
      vld      <= (level_nxt != '0);
      sticky   <= sticky_nxt;
      any_viol <= |sticky_nxt;
      if (clr)                               drop_cnt <= CNT_W'(drop);
      else if (drop && drop_cnt != CNT_MAX)  drop_cnt <= drop_cnt + 1'b1;
      // A hit on the clearing edge survives the clear.
      for (int i = 0; i < NUM_PROPS; i++) begin
        if (clr)                              cnt[i] <= CNT_W'(hits[i]);
        else if (hits[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
      end
      cnt_rdata <= cnt_sel_val;
    end
  end
endmodule

// File: tb/tb_ltl_violation_collector.sv
// Randomized + directed bench for ltl_violation_collector against a queue-based reference model.
module tb_ltl_violation_collector;
  localparam int NP = 9;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  symbols = '0;
  logic [8:0]  viol = '0;
  logic        clr = 1'b0;
  logic        evt_ready = 1'b0;
  logic [3:0]  cnt_sel = '0;
  logic        evt_valid;
  logic [31:0] evt_stamp;
  logic [7:0]  evt_symbol;
  logic [8:0]  evt_viol;
  logic [3:0]  fifo_level;
  logic [8:0]  sticky;
  logic        any_viol;
  logic [3:0]  drop_cnt;
  logic [3:0]  cnt_rdata;

  ltl_violation_collector #(.NUM_PROPS(NP), .DEPTH(DEPTH), .STAMP_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols), .viol(viol), .clr(clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_stamp(evt_stamp),
    .evt_symbol(evt_symbol), .evt_viol(evt_viol), .fifo_level(fifo_level),
    .sticky(sticky), .any_viol(any_viol), .drop_cnt(drop_cnt),
    .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] st;
    logic [7:0]  sy;
    logic [8:0]  v;
  } ev_t;

  ev_t         mq[$];
  logic [31:0] m_stamp;
  logic [8:0]  m_sticky;
  int          m_cnt[NP];
  int          m_drop;
  int          m_rdata;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_stamp = '0;
    m_sticky = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_drop = 0;
    m_rdata = 0;
  endtask

  // Applies the rules of one rising edge using the inputs present before it.
  task automatic model_step();
    bit was_full, popped, dropped;
    m_rdata  = (int'(cnt_sel) < NP) ? m_cnt[cnt_sel] : 0;
    was_full = (mq.size() == DEPTH);
    popped   = (mq.size() != 0) && evt_ready;
    dropped  = 0;
    if (popped) void'(mq.pop_front());
    if (run && viol != 0) begin
      if (was_full && !popped) dropped = 1;
      else mq.push_back('{st: m_stamp, sy: symbols, v: viol});
    end
    if (clr) m_drop = dropped ? 1 : 0;
    else if (dropped && m_drop < CMAX) m_drop++;
    m_sticky = (clr ? 9'h0 : m_sticky) | (run ? viol : 9'h0);
    for (int i = 0; i < NP; i++) begin
      bit h;
      h = run && viol[i];
      if (clr) m_cnt[i] = h ? 1 : 0;
      else if (h && m_cnt[i] < CMAX) m_cnt[i]++;
    end
    if (run) m_stamp = m_stamp + 32'd1;
  endtask

  task automatic check_all();
    bit ne;
    ne = (mq.size() != 0);
    check("valid",  64'(evt_valid),  64'(ne));
    check("stamp",  64'(evt_stamp),  ne ? 64'(mq[0].st) : 64'd0);
    check("symbol", 64'(evt_symbol), ne ? 64'(mq[0].sy) : 64'd0);
    check("viol",   64'(evt_viol),   ne ? 64'(mq[0].v)  : 64'd0);
    check("level",  64'(fifo_level), 64'(mq.size()));
    check("sticky", 64'(sticky),     64'(m_sticky));
    check("any",    64'(any_viol),   64'(m_sticky != 0));
    check("drop",   64'(drop_cnt),   64'(m_drop));
    check("rdata",  64'(cnt_rdata),  64'(m_rdata));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cyc(input bit r, input logic [7:0] sy, input logic [8:0] v,
                     input bit c, input bit rd, input logic [3:0] sl);
    run = r; symbols = sy; viol = v; clr = c; evt_ready = rd; cnt_sel = sl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    run = 0; symbols = '0; viol = '0; clr = 0; evt_ready = 0; cnt_sel = '0;
  endtask

  // Asserts reset between clock edges and checks the outputs clear without an edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check({tag, "_valid"},  64'(evt_valid),  64'd0);
    check({tag, "_level"},  64'(fifo_level), 64'd0);
    check({tag, "_sticky"}, 64'(sticky),     64'd0);
    check({tag, "_any"},    64'(any_viol),   64'd0);
    check({tag, "_stamp"},  64'(evt_stamp),  64'd0);
    check({tag, "_drop"},   64'(drop_cnt),   64'd0);
    check({tag, "_rdata"},  64'(cnt_rdata),  64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check("rst0_valid", 64'(evt_valid), 64'd0);
    check("rst0_level", 64'(fifo_level), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // run=0 masks everything and freezes the stamp
    for (int i = 0; i < 3; i++) cyc(0, 8'h11, 9'h1FF, 0, 0, 4'd0);
    for (int i = 0; i < 5; i++) cyc(1, 8'h00, 9'h000, 0, 0, 4'd0);
    cyc(1, 8'hA5, 9'h004, 0, 0, 4'd0);
    check("tp1_stamp", 64'(evt_stamp), 64'd5);
    check("tp1_sym",   64'(evt_symbol), 64'hA5);
    check("tp1_sticky", 64'(sticky), 64'h004);
    cyc(1, 8'h00, 9'h000, 0, 1, 4'd0);
    cyc(1, 8'h00, 9'h000, 0, 1, 4'd0);

    // overflow: 10 pushes into 8 entries, then full + pop + push
    do_reset("rst1");
    for (int i = 0; i < 10; i++) cyc(1, 8'(i), 9'h001, 0, 0, 4'd0);
    check("tp3_level", 64'(fifo_level), 64'd8);
    check("tp3_drop",  64'(drop_cnt), 64'd2);
    cyc(1, 8'h77, 9'h001, 0, 1, 4'd0);
    check("tp4_level", 64'(fifo_level), 64'd8);
    check("tp4_drop",  64'(drop_cnt), 64'd2);
    for (int i = 0; i < 9; i++) cyc(1, 8'h00, 9'h000, 0, 1, 4'd0);

    // counter saturation and readout
    do_reset("rst2");
    for (int i = 0; i < 20; i++) cyc(1, 8'h33, 9'h008, 0, 1, 4'd0);
    cyc(1, 8'h00, 9'h000, 0, 1, 4'd3);
    check("tp5_sat", 64'(cnt_rdata), 64'd15);
    cyc(1, 8'h00, 9'h000, 0, 1, 4'd12);
    cyc(1, 8'h00, 9'h000, 0, 1, 4'd0);

    // clear coincident with a hit, then reset mid-drain
    cyc(1, 8'h44, 9'h1FF, 0, 0, 4'd0);
    cyc(1, 8'h55, 9'h002, 1, 0, 4'd0);
    check("tp6_sticky", 64'(sticky), 64'h002);
    cyc(1, 8'h00, 9'h000, 0, 0, 4'd1);
    cyc(1, 8'h00, 9'h000, 0, 0, 4'd3);
    cyc(1, 8'h00, 9'h000, 0, 1, 4'd0);
    do_reset("rst3");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, c, rd;
      logic [8:0] v;
      r  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 2) == 0) ? 9'h0 : 9'($urandom);
      c  = ($urandom_range(0, 40) == 0);
      rd = ($urandom_range(0, 3) == 0);
      cyc(r, 8'($urandom), v, c, rd, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
